uart_block_sender: RTL and testbench
====================================

UART_BLOCK_SENDER -- requirements
Module: uart_block_sender

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16; bytes per block (AES-128 block).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 8192; max clocks to wait for tx_done per byte.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port block_valid  input  1  upstream block (ciphertext) present.
REQ-006 SHALL have port block_data  input  8*NUM_BYTES  block to send; bits [127:120] are byte 0.
REQ-007 SHALL have port block_ready  output  1  sender idle, accepts block this cycle.
REQ-008 SHALL have port tx_drive  output  1  one-cycle start request to UART transmitter.
REQ-009 SHALL have port tx_byte_in  output  8  byte presented with tx_drive.
REQ-010 SHALL have port tx_done  input  1  UART one-cycle end-of-stop-bit pulse.
REQ-011 SHALL have port busy  output  1  block transfer in progress.
REQ-012 SHALL have port block_sent  output  1  one-cycle pulse, all NUM_BYTES bytes completed.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse, transfer aborted on timeout.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, WAIT_DONE, FINISH.
REQ-015 IDLE: block_ready=1; on block_valid&&block_ready, SHALL latch block_data into shift register, clear byte index and timer, go SEND next cycle.
REQ-016 SEND: SHALL drive tx_drive=1 for exactly one cycle with tx_byte_in = current byte, then go WAIT_DONE.
REQ-017 tx_byte_in SHALL hold the current byte stable from SEND until tx_done for that byte.
REQ-018 WAIT_DONE: timer SHALL increment each cycle; on tx_done, timer cleared, byte index increments.
REQ-019 WAIT_DONE on tx_done: SHALL go SEND if index < NUM_BYTES-1, else FINISH; first re-issued tx_drive SHALL be the cycle after tx_done (transmitter back in IDLE).
REQ-020 Byte order SHALL be MSB-first: byte 0 = block_data[127:120], byte 15 = block_data[7:0].
REQ-021 FINISH: SHALL pulse block_sent for one cycle, return to IDLE; block_ready reasserts the following cycle.
REQ-022 WAIT_DONE with timer = TIMEOUT_CLKS-1 and no tx_done: SHALL pulse timeout_err, discard remaining bytes, go IDLE; block_sent NOT asserted.
REQ-023 tx_done and timeout on same cycle: tx_done SHALL win (no timeout_err).
REQ-024 tx_done received in IDLE, SEND or FINISH SHALL be ignored.
REQ-025 block_valid while busy SHALL be ignored; data not latched (no buffering).
REQ-026 busy SHALL equal (state != IDLE); block_ready SHALL equal (state == IDLE).
REQ-027 Byte index SHALL be $clog2(NUM_BYTES) bits; timer $clog2(TIMEOUT_CLKS)+1 bits, no wrap.
REQ-028 Illegal state encoding SHALL return to IDLE.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, tx_drive=0, tx_byte_in=8'h00, busy=0, block_sent=0, timeout_err=0, block_ready=1 after release, index and timer 0.
REQ-030 Reset mid-transfer SHALL abandon the block silently; no block_sent or timeout_err pulse.

Structure
REQ-031 State enum, NUM_BYTES default and byte-order definition SHALL live in shared package aes_uart_pkg.
REQ-032 Timeout counter SHALL be sub-module byte_timeout_timer (clear, enable, expired).
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 Block 128'h69c4e0d86a7b0430d8cdb78070b4c55a with UART model (tx_done 10 cycles after tx_drive) -> 16 tx_drive pulses, bytes 69,c4,e0,...,c5,5a in order, block_sent once.
REQ-035 Real transmitter (CLKS_PER_BIT=4) loopback receiver -> received bytes equal the above; no tx_drive while transmitter active.
REQ-036 No tx_done after byte 3 (TIMEOUT_CLKS=64) -> timeout_err pulse 64 cycles after 4th tx_drive, back to IDLE, no block_sent.
REQ-037 block_valid pulsed with 128'hFFFF...FF during busy -> ignored; output stream matches first block only.
REQ-038 reset asserted after byte 7 tx_done -> outputs at reset values same cycle; next block sends from byte 0.
REQ-039 tx_done coincident with timer expiry -> transfer continues, no timeout_err.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES block to UART byte-stream path.
// Byte 0 of a block is its most significant byte.
package aes_uart_pkg;

   localparam int unsigned BYTE_W               = 8;
   localparam int unsigned NUM_BYTES_DEFAULT    = 16;
   localparam int unsigned TIMEOUT_CLKS_DEFAULT = 8192;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2,
      FINISH    = 2'd3
   } state_t;

   // LSB position of byte idx inside a num_bytes-wide block (MSB-first order)
   function automatic int unsigned byte_lsb(input int unsigned num_bytes,
                                            input int unsigned idx);
      return BYTE_W * (num_bytes - 1 - idx);
   endfunction

endpackage

// File: rtl/uart_block_sender_if.sv
// Block handshake plus UART transmitter start/done signals of the block sender.
// master is the sender side, slave is the upstream/transmitter side.
interface uart_block_sender_if
   import aes_uart_pkg::*;
#(
   parameter int unsigned NUM_BYTES = NUM_BYTES_DEFAULT
) ();

   logic                          block_valid;
   logic [BYTE_W*NUM_BYTES-1:0]   block_data;
   logic                          block_ready;
   logic                          tx_drive;
   logic [BYTE_W-1:0]             tx_byte_in;
   logic                          tx_done;
   logic                          busy;
   logic                          block_sent;
   logic                          timeout_err;

   modport master (
      input  block_valid, block_data, tx_done,
      output block_ready, tx_drive, tx_byte_in, busy, block_sent, timeout_err
   );

   modport slave (
      output block_valid, block_data, tx_done,
      input  block_ready, tx_drive, tx_byte_in, busy, block_sent, timeout_err
   );

endinterface

// File: rtl/byte_timeout_timer.sv
// Per-byte watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CLKS-1. Saturates instead of wrapping.
module byte_timeout_timer #(
   parameter int unsigned TIMEOUT_CLKS = 8192
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned       CNT_W = $clog2(TIMEOUT_CLKS) + 1;
   localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CLKS - 1);
   localparam logic [CNT_W-1:0]  SAT   = CNT_W'(TIMEOUT_CLKS);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_n;

   always_comb begin
      count_n = count;
      if (clear) begin
         count_n = '0;
      end else if (enable && (count != SAT)) begin
         count_n = count + CNT_W'(1);
      end
   end

   // expired is registered alongside the count so it never lags it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         expired <= (LIMIT == CNT_W'(0));
      end else begin
         count   <= count_n;
         expired <= (count_n == LIMIT);
      end
   end

endmodule

// File: rtl/uart_block_sender.sv
// Streams a NUM_BYTES block to a byte-wide UART transmitter, byte 0 first,
// one byte per tx_drive/tx_done handshake, aborting if tx_done never comes.
module uart_block_sender
   import aes_uart_pkg::*;
#(
   parameter int unsigned NUM_BYTES    = NUM_BYTES_DEFAULT,
   parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   uart_block_sender_if.master bus
);

   localparam int unsigned BLOCK_W = BYTE_W * NUM_BYTES;
   localparam int unsigned IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   state_t             state;
   state_t             state_n;
   logic [BLOCK_W-1:0] shreg;
   logic [IDX_W-1:0]   byte_idx;
   logic               last_byte;
   logic               accept;
   logic               done;
   logic               timed_out;
   logic               timer_clear;
   logic               timer_en;
   logic               timer_expired;

   assign last_byte = (byte_idx == IDX_W'(NUM_BYTES - 1));

   // Timer runs from the tx_drive cycle, so expiry is measured from the start request
   byte_timeout_timer #(
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic; tx_done outside WAIT_DONE falls through untouched
   always_comb begin
      state_n     = state;
      accept      = 1'b0;
      done        = 1'b0;
      timed_out   = 1'b0;
      timer_en    = 1'b0;
      timer_clear = 1'b0;
      case (state)
         IDLE: begin
            if (bus.block_valid) begin
               accept  = 1'b1;
               state_n = SEND;
            end
         end
         SEND: begin
            timer_en = 1'b1;
            state_n  = WAIT_DONE;
         end
         WAIT_DONE: begin
            timer_en = 1'b1;
            if (bus.tx_done) begin
               done    = 1'b1;
               state_n = last_byte ? FINISH : SEND;
            end else if (timer_expired) begin
               timed_out = 1'b1;
               state_n   = IDLE;
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      timer_clear = accept || done || (state_n == IDLE);
   end

   // Outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg           <= '0;
         byte_idx        <= '0;
         bus.tx_drive    <= 1'b0;
         bus.tx_byte_in  <= '0;
         bus.busy        <= 1'b0;
         bus.block_ready <= 1'b1;
         bus.block_sent  <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.tx_drive    <= (state_n == SEND);
         bus.busy        <= (state_n != IDLE);
         bus.block_ready <= (state_n == IDLE);
         bus.block_sent  <= (state_n == FINISH);
         bus.timeout_err <= timed_out;
         if (accept) begin
            shreg          <= bus.block_data;
            byte_idx       <= '0;
            bus.tx_byte_in <= bus.block_data[byte_lsb(NUM_BYTES, 0) +: BYTE_W];
         end else if (done) begin
            shreg    <= shreg << BYTE_W;
            byte_idx <= byte_idx + IDX_W'(1);
            if (!last_byte) begin
               bus.tx_byte_in <= shreg[byte_lsb(NUM_BYTES, 1) +: BYTE_W];
            end
         end else if (state_n == IDLE) begin
            byte_idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_block_sender.sv
// Randomized scoreboard bench for uart_block_sender with a behavioural UART
// transmitter model that answers tx_drive with tx_done after a chosen delay.
module tb_uart_block_sender;
   import aes_uart_pkg::*;

   localparam int unsigned NB = 16;
   localparam int unsigned TO = 64;
   localparam int unsigned BW = NB * BYTE_W;
   localparam logic [BW-1:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   uart_block_sender_if #(.NUM_BYTES(NB)) bus ();

   uart_block_sender #(
      .NUM_BYTES    (NB),
      .TIMEOUT_CLKS (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks       = 0;
   int          fails        = 0;
   int unsigned cyc          = 0;
   logic [7:0]  exp_q[$];
   int          pending_sent = 0;
   int          sent_count   = 0;
   int          to_count     = 0;
   int          drive_count  = 0;
   int          done_count   = 0;
   int          resp_left    = 0;
   int          fixed_delay  = 0;
   bit          expect_to    = 1'b0;
   bit          stray_req    = 1'b0;
   longint      exp_to_cyc   = -1;
   bit          uart_active  = 1'b0;
   bit          was_active   = 1'b0;
   int          uart_cnt     = 0;
   int          uart_delay   = 0;
   logic [7:0]  uart_byte    = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [BW-1:0] rand_block();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // UART model plus scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         bus.tx_done = 1'b0;
         uart_active = 1'b0;
      end else begin
         bus.tx_done = stray_req;
         stray_req   = 1'b0;
         was_active  = uart_active;
         if (uart_active) begin
            check("byte_stable", bus.tx_byte_in, uart_byte);
            uart_cnt++;
            if (uart_cnt == uart_delay) begin
               bus.tx_done = 1'b1;
               uart_active = 1'b0;
               done_count++;
            end
         end
         if (bus.tx_drive) begin
            drive_count++;
            check("no_drive_while_tx_active", was_active, 1'b0);
            if (exp_q.size() == 0) check("unexpected_tx_drive", 1'b1, 1'b0);
            else check("byte_order", bus.tx_byte_in, exp_q.pop_front());
            if (resp_left > 0) begin
               resp_left--;
               uart_active = 1'b1;
               uart_cnt    = 0;
               uart_byte   = bus.tx_byte_in;
               uart_delay  = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 20));
            end else if (expect_to) begin
               exp_to_cyc = longint'(cyc) + longint'(TO);
               expect_to  = 1'b0;
            end
         end
         if (bus.block_sent) begin
            sent_count++;
            if (pending_sent == 0) check("unexpected_block_sent", 1'b1, 1'b0);
            else begin
               pending_sent--;
               check("sent_after_all_bytes", exp_q.size(), 0);
            end
         end
         if (bus.timeout_err) begin
            to_count++;
            if (exp_to_cyc < 0) check("unexpected_timeout_err", 1'b1, 1'b0);
            else begin
               check("timeout_cycle", 128'(cyc), 128'(exp_to_cyc));
               exp_to_cyc = -1;
            end
         end
         check("ready_is_not_busy", bus.block_ready, !bus.busy);
      end
   end

   task automatic wait_idle(input int limit);
      int g = 0;
      while (!(bus.block_ready && !bus.busy) && g < limit) begin
         @(negedge clk);
         g++;
      end
      check("idle_within_budget", bus.block_ready && !bus.busy, 1'b1);
   endtask

   task automatic issue_block(input logic [BW-1:0] data, input int n_exp);
      @(negedge clk);
      wait_idle(5000);
      for (int i = 0; i < n_exp; i++) exp_q.push_back(8'(data >> (8 * (NB - 1 - i))));
      bus.block_valid = 1'b1;
      bus.block_data  = data;
      @(negedge clk);
      bus.block_valid = 1'b0;
      check("busy_after_accept", bus.busy, 1'b1);
   endtask

   task automatic run_block(input logic [BW-1:0] data, input int fdelay, input int resp,
                            input int n_exp, input bit want_to, input int inject_at);
      int d0 = drive_count;
      int s0 = sent_count;
      int t0 = to_count;
      fixed_delay = fdelay;
      resp_left   = resp;
      expect_to   = want_to;
      if (!want_to) pending_sent++;
      issue_block(data, n_exp);
      if (inject_at > 0) begin
         repeat (inject_at) @(negedge clk);
         check("busy_at_inject", bus.busy, 1'b1);
         bus.block_valid = 1'b1;
         bus.block_data  = '1;
         @(negedge clk);
         bus.block_valid = 1'b0;
         bus.block_data  = '0;
      end
      wait_idle(4000);
      repeat (2) @(negedge clk);
      check("drive_count", drive_count - d0, n_exp);
      check("block_sent_count", sent_count - s0, want_to ? 0 : 1);
      check("timeout_count", to_count - t0, want_to ? 1 : 0);
      check("expected_bytes_drained", exp_q.size(), 0);
   endtask

   initial begin
      int base;
      int g;
      int d0;
      bus.block_valid = 1'b0;
      bus.block_data  = '0;

      repeat (3) @(negedge clk);
      check("rst_tx_drive", bus.tx_drive, 1'b0);
      check("rst_tx_byte_in", bus.tx_byte_in, 8'h00);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_block_sent", bus.block_sent, 1'b0);
      check("rst_timeout_err", bus.timeout_err, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_release_ready", bus.block_ready, 1'b1);

      // Known vector with a fixed 10-cycle UART
      run_block(KAT, 10, NB, NB, 1'b0, 0);

      // Random blocks, random per-byte tx_done latency
      for (int k = 0; k < 4; k++) run_block(rand_block(), 0, NB, NB, 1'b0, 0);

      // block_valid with all-ones while busy must be dropped
      run_block(rand_block(), 0, NB, NB, 1'b0, 25);

      // Stray tx_done while idle
      d0 = drive_count;
      stray_req = 1'b1;
      repeat (5) @(negedge clk);
      check("stray_done_no_drive", drive_count - d0, 0);
      check("stray_done_idle", bus.busy, 1'b0);

      // UART stops answering from byte 3 on
      run_block(rand_block(), 10, 3, 4, 1'b1, 0);

      // tx_done on the exact expiry cycle keeps the transfer alive
      run_block(rand_block(), int'(TO) - 1, NB, NB, 1'b0, 0);

      // Reset just after byte 7 completes
      fixed_delay = 10;
      resp_left   = NB;
      pending_sent++;
      base = done_count;
      issue_block(rand_block(), NB);
      g = 0;
      while (done_count < base + 8 && g < 3000) begin
         @(negedge clk);
         g++;
      end
      check("byte7_done_seen", done_count - base, 8);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_tx_drive", bus.tx_drive, 1'b0);
      check("midrst_tx_byte_in", bus.tx_byte_in, 8'h00);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_block_sent", bus.block_sent, 1'b0);
      check("midrst_timeout_err", bus.timeout_err, 1'b0);
      exp_q.delete();
      pending_sent = 0;
      resp_left    = 0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("midrst_release_ready", bus.block_ready, 1'b1);
      run_block(rand_block(), 0, NB, NB, 1'b0, 0);

      check("total_timeouts", to_count, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
